vga_timing_gen: RTL and testbench

Parametrised VGA/raster timing generator. Second-generation replacement for the fixed 640x480 timing block. Divides the system clock down to a pixel strobe and generates h/v counters, sync pulses with selectable polarity, data-enable, pixel coordinates, line/frame start strobes and a frame counter. Sits between the system clock domain and the pixel-colour logic: the game renderer consumes x_out/y_out/de_out and drives rgb.

---
 rtl/vga_timing_gen.sv | 212 +++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-strobe divider, h/v counters,
// sync/enable decode, line/frame strobes and a completed-frame counter.

module vga_timing_gen_chk #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) ();

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("vga_timing_gen: horizontal timing values must be >= 1");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("vga_timing_gen: vertical timing values must be >= 1");
  end
  if (H_TOTAL >= (1 << X_W)) begin : g_bad_xw
    $error("vga_timing_gen: X_W too narrow for H_TOTAL");
  end
  if (V_TOTAL >= (1 << Y_W)) begin : g_bad_yw
    $error("vga_timing_gen: Y_W too narrow for V_TOTAL");
  end

endmodule

module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int FC_W     = 8
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            en_in,
  output logic            pix_en_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            de_out,
  output logic [X_W-1:0]  x_out,
  output logic [Y_W-1:0]  y_out,
  output logic            line_start_out,
  output logic            frame_start_out,
  output logic [FC_W-1:0] frame_cnt_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0]   X_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0]   HS_BEG   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0]   Y_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]   VS_BEG   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON    = (HS_POL != 0);
  localparam logic             VS_ON    = (VS_POL != 0);

  vga_timing_gen_chk #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .X_W     (X_W),
    .Y_W     (Y_W)
  ) u_chk ();

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nx_s;
  logic             wrap_s;
  logic [X_W-1:0]   x_r;
  logic [X_W-1:0]   x_nx_s;
  logic [Y_W-1:0]   y_r;
  logic [Y_W-1:0]   y_nx_s;
  logic             hs_nx_s;
  logic             vs_nx_s;
  logic             de_nx_s;
  logic             ls_nx_s;
  logic             fs_nx_s;
  logic             pix_en_r;
  logic             hs_r;
  logic             vs_r;
  logic             de_r;
  logic             ls_r;
  logic             fs_r;
  logic             first_seen_r;
  logic [FC_W-1:0]  fc_r;

  // Next divider/position and the decode of that next position, so every
  // registered output lines up with the x/y it is stored alongside.
  always_comb begin
    wrap_s = (div_r == DIV_LAST);
    if (wrap_s) begin
      div_nx_s = {DIV_W{1'b0}};
    end else begin
      div_nx_s = div_r + 1'b1;
    end

    if (x_r == X_LAST) begin
      x_nx_s = {X_W{1'b0}};
      if (y_r == Y_LAST) begin
        y_nx_s = {Y_W{1'b0}};
      end else begin
        y_nx_s = y_r + 1'b1;
      end
    end else begin
      x_nx_s = x_r + 1'b1;
      y_nx_s = y_r;
    end

    if ((x_nx_s >= HS_BEG) && (x_nx_s < HS_END)) begin
      hs_nx_s = HS_ON;
    end else begin
      hs_nx_s = ~HS_ON;
    end
    if ((y_nx_s >= VS_BEG) && (y_nx_s < VS_END)) begin
      vs_nx_s = VS_ON;
    end else begin
      vs_nx_s = ~VS_ON;
    end
    de_nx_s = (x_nx_s < X_ACT) && (y_nx_s < Y_ACT);
    ls_nx_s = (x_nx_s == {X_W{1'b0}});
    fs_nx_s = ls_nx_s && (y_nx_s == {Y_W{1'b0}});
  end

  // Timing state: divider always runs while enabled; position and decoded
  // outputs only move on the divider wrap. The first frame start after reset
  // is not a completed frame, so it only arms the counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_r        <= {DIV_W{1'b0}};
      x_r          <= X_LAST;
      y_r          <= Y_LAST;
      pix_en_r     <= 1'b0;
      hs_r         <= ~HS_ON;
      vs_r         <= ~VS_ON;
      de_r         <= 1'b0;
      ls_r         <= 1'b0;
      fs_r         <= 1'b0;
      first_seen_r <= 1'b0;
      fc_r         <= {FC_W{1'b0}};
    end else if (!en_in) begin
      pix_en_r <= 1'b0;
      ls_r     <= 1'b0;
      fs_r     <= 1'b0;
    end else begin
      div_r    <= div_nx_s;
      pix_en_r <= wrap_s;
      if (wrap_s) begin
        x_r  <= x_nx_s;
        y_r  <= y_nx_s;
        hs_r <= hs_nx_s;
        vs_r <= vs_nx_s;
        de_r <= de_nx_s;
        ls_r <= ls_nx_s;
        fs_r <= fs_nx_s;
        if (fs_nx_s) begin
          if (first_seen_r) begin
            fc_r <= fc_r + 1'b1;
          end else begin
            first_seen_r <= 1'b1;
          end
        end
      end else begin
        ls_r <= 1'b0;
        fs_r <= 1'b0;
      end
    end
  end

  assign pix_en_out      = pix_en_r;
  assign hs_out          = hs_r;
  assign vs_out          = vs_r;
  assign de_out          = de_r;
  assign x_out           = x_r;
  assign y_out           = y_r;
  assign line_start_out  = ls_r;
  assign frame_start_out = fs_r;
  assign frame_cnt_out   = fc_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance driven by a vector table
// plus hand sequences, and a tiny instance checked against a queued model.

module tb_vga_timing_gen;

  typedef struct packed {
    logic       pix;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int   n;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       rst_a, en_a, pix_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic [7:0] fc_a;

  // small instance
  logic       rst_b, en_b, pix_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [3:0] x_b;
  logic [2:0] y_b;
  logic [1:0] fc_b;

  int n_vec = 0;
  int n_err = 0;

  vga_timing_gen u_dut_a (
    .clk_in         (clk),
    .rst_n_in       (rst_a),
    .en_in          (en_a),
    .pix_en_out     (pix_a),
    .hs_out         (hs_a),
    .vs_out         (vs_a),
    .de_out         (de_a),
    .x_out          (x_a),
    .y_out          (y_a),
    .line_start_out (ls_a),
    .frame_start_out(fs_a),
    .frame_cnt_out  (fc_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .X_W(4), .Y_W(3), .FC_W(2)
  ) u_dut_b (
    .clk_in         (clk),
    .rst_n_in       (rst_b),
    .en_in          (en_b),
    .pix_en_out     (pix_b),
    .hs_out         (hs_b),
    .vs_out         (vs_b),
    .de_out         (de_b),
    .x_out          (x_b),
    .y_out          (y_b),
    .line_start_out (ls_b),
    .frame_start_out(fs_b),
    .frame_cnt_out  (fc_b)
  );

  function automatic obs_t mk(input logic pix, input logic hs, input logic vs,
                              input logic de, input logic ls, input logic fs,
                              input int x, input int y, input int fc);
    obs_t o;
    o.pix = pix; o.hs = hs; o.vs = vs; o.de = de; o.ls = ls; o.fs = fs;
    o.x = 10'(x); o.y = 10'(y); o.fc = 8'(fc);
    return o;
  endfunction

  function automatic obs_t obs_a();
    return mk(pix_a, hs_a, vs_a, de_a, ls_a, fs_a, int'(x_a), int'(y_a), int'(fc_a));
  endfunction

  function automatic obs_t obs_b();
    return mk(pix_b, hs_b, vs_b, de_b, ls_b, fs_b, int'(x_b), int'(y_b), int'(fc_b));
  endfunction

  // Reference for the small config after k pixel strobes (closed form).
  function automatic obs_t model_b(input int k, input logic pix);
    int p, x, y, fc;
    if (k == 0) return mk(pix, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 5, 0);
    p  = k - 1;
    x  = p % 8;
    y  = (p / 8) % 6;
    fc = (p / 48) % 4;
    return mk(pix, (x == 5 || x == 6), (y == 4), (x < 4 && y < 3),
              pix && (x == 0), pix && (x == 0) && (y == 0), x, y, fc);
  endfunction

  task automatic chk(input string nm, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: actual pix%b hs%b vs%b de%b ls%b fs%b x%0d y%0d fc%0d, required pix%b hs%b vs%b de%b ls%b fs%b x%0d y%0d fc%0d",
               nm, got.pix, got.hs, got.vs, got.de, got.ls, got.fs, got.x, got.y, got.fc,
               exp.pix, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.x, exp.y, exp.fc);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the strobe counter reaches target; clks counts edges.
  task automatic run_to_strobe(input int target, inout int strobes, inout int clks,
                               output logic ok);
    int guard;
    guard = 0;
    ok = 1'b1;
    while (strobes < target) begin
      tick();
      clks++;
      guard++;
      if (pix_a) strobes++;
      if (guard > 5000) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  vec_t tbl[10];
  obs_t sb_q[$];
  obs_t rst_vec_a;
  obs_t frz_vec;
  obs_t exp_o;
  int   strobes, clks, k;
  logic ok;

  initial begin
    rst_vec_a = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 799, 524, 0);
    tbl[0] = '{1,   mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0,   0, 0)};
    tbl[1] = '{2,   mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1,   0, 0)};
    tbl[2] = '{640, mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 639, 0, 0)};
    tbl[3] = '{641, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 640, 0, 0)};
    tbl[4] = '{656, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 655, 0, 0)};
    tbl[5] = '{657, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 656, 0, 0)};
    tbl[6] = '{752, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 751, 0, 0)};
    tbl[7] = '{753, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 752, 0, 0)};
    tbl[8] = '{800, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 799, 0, 0)};
    tbl[9] = '{801, mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0,   1, 0)};

    rst_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0;
    repeat (3) tick();
    chk("reset_a", obs_a(), rst_vec_a);
    chk("reset_b", obs_b(), model_b(0, 1'b0));

    // table: strobe n lands on x=(n-1)%800 after exactly 4n clocks
    rst_a = 1'b1; en_a = 1'b1;
    strobes = 0; clks = 0;
    for (int i = 0; i < 10; i++) begin
      run_to_strobe(tbl[i].n, strobes, clks, ok);
      if (!ok) begin
        chk_int("strobe_timeout", strobes, tbl[i].n);
        break;
      end
      chk($sformatf("vec%0d", i), obs_a(), tbl[i].exp);
      chk_int($sformatf("vec%0d_clk", i), clks, 4 * tbl[i].n);
    end

    // asynchronous reset mid-frame, between clock edges
    @(negedge clk);
    #1 rst_a = 1'b0;
    #1 chk("async_rst", obs_a(), rst_vec_a);
    tick(); tick();
    chk("rst_hold", obs_a(), rst_vec_a);

    // freeze at x=100 with the divider part-way through its count
    rst_a = 1'b1;
    strobes = 0; clks = 0;
    run_to_strobe(101, strobes, clks, ok);
    chk("x100", obs_a(), mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 100, 0, 0));
    frz_vec = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 100, 0, 0);
    tick(); tick();
    chk("pre_freeze", obs_a(), frz_vec);
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("frozen", obs_a(), frz_vec);
    end
    en_a = 1'b1;
    tick();
    chk("resume1", obs_a(), frz_vec);
    tick();
    chk("resume_strobe", obs_a(), mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 101, 0, 0));
    en_a = 1'b0;

    // small config: continuous run then random enable, model-scored
    rst_b = 1'b1;
    k = 0;
    for (int i = 0; i < 600; i++) begin
      en_b = (i < 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (en_b) k++;
      sb_q.push_back(model_b(k, en_b));
      tick();
      if (sb_q.size() == 0) begin
        chk_int("sb_empty", 0, 1);
      end else begin
        exp_o = sb_q.pop_front();
        chk($sformatf("sb%0d", i), obs_b(), exp_o);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
